clock_key_ctrl: RTL and testbench
=================================

Name: clock_key_ctrl

Overview:
- Front-panel input controller for the millennium clock: the control-side counterpart of the 7-segment display driver.
- Debounces three raw push buttons (MODE, SET, UP) and runs the edit-mode state machine.
- Produces the view-select, edit-enable and field-select signals the display driver consumes (smh_dmy, dem_chinh, blink_led).
- Produces a one-cycle increment strobe for the time/date counter block.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized cycles required to accept a button level change (20 ms at 50 MHz).
- HOLD_CYCLES, 25_000_000, cycles UP must stay held after its press event before auto-repeat starts.
- REPEAT_CYCLES, 5_000_000, auto-repeat period for inc_pulse while UP is held.
- TIMEOUT_CYCLES, 500_000_000, idle cycles in edit mode before forced return to RUN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_mode_n  in  1  raw MODE button, active-low, asynchronous to clk.
- btn_set_n  in  1  raw SET button, active-low, asynchronous.
- btn_up_n  in  1  raw UP button, active-low, asynchronous.
- smh_dmy  out  1  0 = hh:mm:ss view, 1 = dd.mo.yyyy view.
- dem_chinh  out  1  1 while in an edit state.
- blink_led  out  2  field under edit: 00 none, 01/10/11 = field 1/2/3.
- inc_pulse  out  1  one-cycle increment strobe for the selected field.

Behaviour:
- Reset (async, rst_n low): smh_dmy=0, dem_chinh=0, blink_led=00, inc_pulse=0, state=RUN. All debouncers, repeat counters and timeout counters clear. Stable level = released.
- Debounce, per button:
  - Raw input passes a 2-flop synchronizer, then is inverted to active-high s.
  - Counter cnt increments each cycle that s != stable, and clears whenever s == stable.
  - When s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s and cnt <= 0.
  - press_evt is a registered 1-cycle pulse on the same edge that stable goes 0->1. Releases produce no event.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Latency: a clean raw press gives press_evt on edge 2+DEBOUNCE_CYCLES. The FSM and outputs update on the following edge.
- States: RUN, EDIT_F1, EDIT_F2, EDIT_F3.
  - dem_chinh = 1 in any EDIT state.
  - blink_led = 00 in RUN, 01 in EDIT_F1, 10 in EDIT_F2, 11 in EDIT_F3.
- Field meaning:
  - smh_dmy=0: F1 = hours, F2 = minutes, F3 = seconds.
  - smh_dmy=1: F1 = day, F2 = month, F3 = year.
- SET press: RUN->EDIT_F1->EDIT_F2->EDIT_F3->RUN.
- MODE press: toggles smh_dmy in RUN only. Ignored in EDIT states, so the view never changes mid-edit.
- UP press in an EDIT state: inc_pulse=1 for exactly one cycle. Ignored in RUN (no pulse).
- Auto-repeat (EDIT states only):
  - While UP stable stays pressed, a hold counter runs from the UP press event.
  - After HOLD_CYCLES, inc_pulse fires, then fires again every REPEAT_CYCLES.
  - Release, leaving EDIT, or any SET/MODE event stops and clears the repeat.
- Simultaneous events in one cycle: priority SET > MODE > UP; lower-priority events that cycle are discarded.
- Timeout:
  - In EDIT states, an idle counter clears on any press event or auto-repeat pulse.
  - Reaching TIMEOUT_CYCLES-1 forces RUN (dem_chinh=0, blink_led=00) on the next edge. smh_dmy is kept.
  - The counter is held at 0 in RUN.
- inc_pulse is never asserted in RUN and never on two consecutive cycles.
- All counters are sized with $clog2 of their parameter and saturate/clear without wrap-around.
- Reset mid-edit returns to RUN immediately and asynchronously. No inc_pulse is produced after reset release until a new debounced event.

Decomposition:
- Package clock_key_pkg holds:
  - the state enum (RUN, EDIT_F1..F3);
  - blink_led field codes (FIELD_NONE=00, F1=01, F2=10, F3=11);
  - view codes (VIEW_TIME=0, VIEW_DATE=1).
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, key_n, stable, press_evt) is instantiated three times.
- The FSM, repeat logic and timeout logic stay in clock_key_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, TIMEOUT_CYCLES=100):
- Reset, then MODE held low 10 cycles: press_evt on edge 6, smh_dmy 0->1 on edge 7. A second press returns it to 0.
- SET glitch low for 3 cycles -> no state change. Four clean SET presses -> blink_led 01,10,11,00 and dem_chinh 1,1,1,0.
- In EDIT_F2, UP held 40 cycles -> inc_pulse at the press event +1 edge, then at +20 and +28 cycles. No pulse after release. UP in RUN -> no pulse.
- In EDIT_F1 with no buttons for 100 cycles -> dem_chinh=0, blink_led=00, smh_dmy unchanged. An UP event at cycle 50 restarts the count.
- SET and UP press events on the same cycle in EDIT_F1 -> state EDIT_F2, no inc_pulse. MODE in EDIT_F3 -> smh_dmy unchanged.
- rst_n pulsed low in EDIT_F3 while UP is auto-repeating -> all outputs 0 asynchronously, no inc_pulse after release while UP stays held.

Source files
------------

// File: rtl/clock_key_pkg.sv
// Shared types and codes for the front-panel key controller of the millennium clock.
package clock_key_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StEditF1 = 2'b01,
        StEditF2 = 2'b10,
        StEditF3 = 2'b11
    } key_state_e;

    localparam logic [1:0] FieldNone = 2'b00;
    localparam logic [1:0] FieldF1   = 2'b01;
    localparam logic [1:0] FieldF2   = 2'b10;
    localparam logic [1:0] FieldF3   = 2'b11;

    localparam logic ViewTime = 1'b0;
    localparam logic ViewDate = 1'b1;

    // SET walks RUN -> F1 -> F2 -> F3 -> RUN.
    function automatic key_state_e next_edit_state(input key_state_e cur);
        key_state_e nxt;
        unique case (cur)
            StRun:    nxt = StEditF1;
            StEditF1: nxt = StEditF2;
            StEditF2: nxt = StEditF3;
            StEditF3: nxt = StRun;
            default:  nxt = StRun;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] field_code(input key_state_e cur);
        logic [1:0] code;
        unique case (cur)
            StRun:    code = FieldNone;
            StEditF1: code = FieldF1;
            StEditF2: code = FieldF2;
            StEditF3: code = FieldF3;
            default:  code = FieldNone;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/clock_key_ctrl_debounce.sv
// Per-button synchronizer and debouncer; emits a one-cycle event when a press is accepted.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic stable,
    output logic press_evt
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            s;
    logic            stable_q, stable_d;
    logic            evt_q, evt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign s = ~sync2_q;

    always_comb begin
        stable_d = stable_q;
        evt_d    = 1'b0;
        cnt_d    = '0;
        if (s != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = s;
                evt_d    = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer resets to the released (high) level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b0;
            evt_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            evt_q    <= evt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable    = stable_q;
    assign press_evt = evt_q;

endmodule

// File: rtl/clock_key_ctrl.sv
// Front-panel controller: debounced MODE/SET/UP, edit-mode FSM, UP auto-repeat and edit timeout.
module clock_key_ctrl
    import clock_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 25_000_000,
    parameter int unsigned REPEAT_CYCLES   = 5_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode_n,
    input  logic       btn_set_n,
    input  logic       btn_up_n,
    output logic       smh_dmy,
    output logic       dem_chinh,
    output logic [1:0] blink_led,
    output logic       inc_pulse
);

    localparam int unsigned RptMax  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RptW    = (RptMax > 1) ? $clog2(RptMax) : 1;
    localparam int unsigned IdleW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [RptW-1:0]  HoldLast   = RptW'(HOLD_CYCLES - 1);
    localparam logic [RptW-1:0]  RepeatLast = RptW'(REPEAT_CYCLES - 1);
    localparam logic [IdleW-1:0] IdleLast   = IdleW'(TIMEOUT_CYCLES - 1);

    logic mode_stable, set_stable, up_stable;
    logic mode_evt, set_evt, up_evt;
    logic unused_stable;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (btn_mode_n),
        .stable    (mode_stable),
        .press_evt (mode_evt)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (btn_set_n),
        .stable    (set_stable),
        .press_evt (set_evt)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (btn_up_n),
        .stable    (up_stable),
        .press_evt (up_evt)
    );

    assign unused_stable = mode_stable ^ set_stable;

    key_state_e       state_q, state_d;
    logic             view_q, view_d;
    logic             inc_q, inc_d;
    logic             rpt_act_q, rpt_act_d;
    logic             rpt_hold_q, rpt_hold_d;
    logic [RptW-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic             in_edit;
    logic             rpt_lim_hit;
    logic             rpt_fire;

    assign in_edit     = (state_q != StRun);
    assign rpt_lim_hit = rpt_hold_q ? (rpt_cnt_q == HoldLast) : (rpt_cnt_q == RepeatLast);
    assign rpt_fire    = in_edit && rpt_act_q && up_stable && rpt_lim_hit;

    always_comb begin
        state_d    = state_q;
        view_d     = view_q;
        inc_d      = 1'b0;
        rpt_act_d  = rpt_act_q;
        rpt_hold_d = rpt_hold_q;
        rpt_cnt_d  = rpt_cnt_q;
        idle_d     = idle_q;

        // Priority chain: SET > MODE > UP > repeat > timeout.
        if (set_evt) begin
            state_d   = next_edit_state(state_q);
            rpt_act_d = 1'b0;
            idle_d    = '0;
        end else if (mode_evt) begin
            if (!in_edit) begin
                view_d = ~view_q;
            end
            rpt_act_d = 1'b0;
            idle_d    = '0;
        end else if (up_evt && in_edit) begin
            inc_d      = 1'b1;
            rpt_act_d  = 1'b1;
            rpt_hold_d = 1'b1;
            // The press-event cycle counts as the first hold cycle.
            rpt_cnt_d  = RptW'(1);
            idle_d     = '0;
        end else if (rpt_fire) begin
            inc_d      = 1'b1;
            rpt_hold_d = 1'b0;
            rpt_cnt_d  = '0;
            idle_d     = '0;
        end else if (in_edit && (idle_q == IdleLast)) begin
            state_d   = StRun;
            rpt_act_d = 1'b0;
            idle_d    = '0;
        end else begin
            if (rpt_act_q && !rpt_lim_hit) begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
            if (in_edit) begin
                idle_d = idle_q + 1'b1;
            end
        end

        if (state_d == StRun) begin
            idle_d    = '0;
            rpt_act_d = 1'b0;
        end
        if (!up_stable) begin
            rpt_act_d = 1'b0;
        end
        if (!rpt_act_d) begin
            rpt_hold_d = 1'b1;
            rpt_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            view_q     <= ViewTime;
            inc_q      <= 1'b0;
            rpt_act_q  <= 1'b0;
            rpt_hold_q <= 1'b1;
            rpt_cnt_q  <= '0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            view_q     <= view_d;
            inc_q      <= inc_d;
            rpt_act_q  <= rpt_act_d;
            rpt_hold_q <= rpt_hold_d;
            rpt_cnt_q  <= rpt_cnt_d;
            idle_q     <= idle_d;
        end
    end

    assign smh_dmy   = view_q;
    assign dem_chinh = in_edit;
    assign blink_led = field_code(state_q);
    assign inc_pulse = inc_q;

endmodule

// File: tb/tb_clock_key_ctrl.sv
// Directed bench for clock_key_ctrl with small debounce/hold/repeat/timeout values.
module tb_clock_key_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode_n = 1'b1;
    logic       btn_set_n = 1'b1;
    logic       btn_up_n = 1'b1;
    logic       smh_dmy;
    logic       dem_chinh;
    logic [1:0] blink_led;
    logic       inc_pulse;

    int   checks = 0;
    int   failures = 0;
    int   inc_cnt = 0;
    int   viol = 0;
    logic prev_inc = 1'b0;

    clock_key_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (8),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode_n (btn_mode_n),
        .btn_set_n  (btn_set_n),
        .btn_up_n   (btn_up_n),
        .smh_dmy    (smh_dmy),
        .dem_chinh  (dem_chinh),
        .blink_led  (blink_led),
        .inc_pulse  (inc_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] btn;    // {mode, set, up}, 1 = pressed
        logic       smh;
        logic       dem;
        logic [1:0] blink;
        int         incs;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (inc_pulse === 1'b1) begin
            inc_cnt++;
            if (prev_inc) viol++;
            if (dem_chinh !== 1'b1) viol++;
        end
        prev_inc = (inc_pulse === 1'b1);
    endtask

    task automatic drive(input logic [2:0] b);
        btn_mode_n = ~b[2];
        btn_set_n  = ~b[1];
        btn_up_n   = ~b[0];
    endtask

    task automatic press(input logic [2:0] b, input int low, input int settle);
        drive(b);
        repeat (low) tick();
        drive(3'b000);
        repeat (settle) tick();
    endtask

    task automatic check_outs(input string name, input logic smh, input logic dem,
                              input logic [1:0] blink);
        check({name, "_smh"}, 32'(smh_dmy), 32'(smh));
        check({name, "_dem"}, 32'(dem_chinh), 32'(dem));
        check({name, "_blink"}, 32'(blink_led), 32'(blink));
    endtask

    initial begin
        int times[$];
        int exp_t[4];

        vecs[0]  = '{3'b100, 1'b1, 1'b0, 2'd0, 0};
        vecs[1]  = '{3'b100, 1'b0, 1'b0, 2'd0, 0};
        vecs[2]  = '{3'b001, 1'b0, 1'b0, 2'd0, 0};  // UP in RUN ignored
        vecs[3]  = '{3'b010, 1'b0, 1'b1, 2'd1, 0};
        vecs[4]  = '{3'b001, 1'b0, 1'b1, 2'd1, 1};
        vecs[5]  = '{3'b010, 1'b0, 1'b1, 2'd2, 0};
        vecs[6]  = '{3'b100, 1'b0, 1'b1, 2'd2, 0};  // MODE ignored mid-edit
        vecs[7]  = '{3'b010, 1'b0, 1'b1, 2'd3, 0};
        vecs[8]  = '{3'b010, 1'b0, 1'b0, 2'd0, 0};
        vecs[9]  = '{3'b100, 1'b1, 1'b0, 2'd0, 0};
        vecs[10] = '{3'b010, 1'b1, 1'b1, 2'd1, 0};
        vecs[11] = '{3'b011, 1'b1, 1'b1, 2'd2, 0};  // SET beats UP
        vecs[12] = '{3'b010, 1'b1, 1'b1, 2'd3, 0};
        vecs[13] = '{3'b100, 1'b1, 1'b1, 2'd3, 0};
        vecs[14] = '{3'b001, 1'b1, 1'b1, 2'd3, 1};
        vecs[15] = '{3'b010, 1'b1, 1'b0, 2'd0, 0};

        // Reset
        repeat (3) tick();
        check_outs("reset", 1'b0, 1'b0, 2'd0);
        check("reset_inc", 32'(inc_pulse), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // MODE latency: press_evt on edge 6, smh_dmy flips on edge 7.
        for (int t = 1; t <= 20; t++) begin
            drive((t <= 10) ? 3'b100 : 3'b000);
            tick();
            if (t == 6) check("mode_lat_e6", 32'(smh_dmy), 32'd0);
            if (t == 7) check("mode_lat_e7", 32'(smh_dmy), 32'd1);
        end
        press(3'b100, 10, 10);
        check("mode_second", 32'(smh_dmy), 32'd0);

        // SET glitch shorter than the debounce window
        press(3'b010, 3, 10);
        check_outs("glitch", 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < 16; i++) begin
            inc_cnt = 0;
            press(vecs[i].btn, 10, 10);
            check_outs($sformatf("vec%0d", i), vecs[i].smh, vecs[i].dem, vecs[i].blink);
            check($sformatf("vec%0d_inc", i), 32'(inc_cnt), 32'(vecs[i].incs));
        end

        // Timeout: F1 entered on edge 7, forced back to RUN on edge 107.
        inc_cnt = 0;
        for (int t = 1; t <= 110; t++) begin
            drive((t <= 10) ? 3'b010 : 3'b000);
            tick();
            if (t == 106) check("tmo_e106_dem", 32'(dem_chinh), 32'd1);
            if (t == 107) check_outs("tmo_e107", 1'b1, 1'b0, 2'd0);
        end
        // UP event on edge 57 (cycle 50 of edit) restarts the count: RUN on edge 158.
        for (int t = 1; t <= 160; t++) begin
            if (t <= 10) drive(3'b010);
            else if (t >= 52 && t <= 59) drive(3'b001);
            else drive(3'b000);
            tick();
            if (t == 107) check("tmo2_e107_dem", 32'(dem_chinh), 32'd1);
            if (t == 157) check("tmo2_e157_dem", 32'(dem_chinh), 32'd1);
            if (t == 158) check_outs("tmo2_e158", 1'b1, 1'b0, 2'd0);
        end
        check("tmo_inc", 32'(inc_cnt), 32'd1);

        // Auto-repeat in F2: UP raw low for 40 cycles, press event on edge 6,
        // pulses on edges 7, 26, 34, 42; stable release on edge 46.
        press(3'b010, 10, 10);
        press(3'b010, 10, 10);
        check("rpt_in_f2", 32'(blink_led), 32'd2);
        exp_t = '{7, 26, 34, 42};
        for (int t = 1; t <= 60; t++) begin
            drive((t <= 40) ? 3'b001 : 3'b000);
            tick();
            if (inc_pulse === 1'b1) times.push_back(t);
        end
        check("rpt_count", 32'(times.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rpt_edge%0d", i), (i < times.size()) ? 32'(times[i]) : 32'hffff_ffff,
                  32'(exp_t[i]));
        end
        press(3'b010, 10, 10);
        press(3'b010, 10, 10);
        check("rpt_back_run", 32'(dem_chinh), 32'd0);

        // Async reset while auto-repeating in F3 with smh_dmy = 1.
        press(3'b010, 10, 10);
        press(3'b010, 10, 10);
        press(3'b010, 10, 10);
        check_outs("pre_rst", 1'b1, 1'b1, 2'd3);
        inc_cnt = 0;
        drive(3'b001);
        repeat (30) tick();
        check("pre_rst_inc", 32'(inc_cnt), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 2'd0);
        check("async_rst_inc", 32'(inc_pulse), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        inc_cnt = 0;
        repeat (60) tick();
        check("post_rst_inc", 32'(inc_cnt), 32'd0);
        check_outs("post_rst", 1'b0, 1'b0, 2'd0);
        drive(3'b000);
        repeat (10) tick();

        check("inc_rules", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
